// File: rtl/radar_window_buffer.sv
// radar_window_buffer
//   Sliding-window buffer for the radar noise-reducer path. Holds the last
//   DEPTH accepted points and presents them as one DEPTH-wide window to the
//   downstream filter kernel. Once the window is full, a window is emitted
//   every STRIDE accepted points. A per-slot mask marks which slots hold real
//   points; empty slots read as FILL_VAL.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset (overrides flush and handshakes)
//   flush      synchronous clear of contents; drops any pending window
//   in_valid   upstream point valid
//   in_ready   buffer can take a point this cycle (combinational)
//   in_data    incoming point
//   win_valid  window available (registered)
//   win_ready  downstream takes the window
//   win_data   slot k at [k*DATA_W +: DATA_W]; slot DEPTH-1 is the newest
//   win_mask   bit k set when slot k holds a real point
//   win_full   fill_cnt == DEPTH
//   fill_cnt   points held, saturates at DEPTH
module radar_window_buffer #(
  parameter int                DATA_W   = 128,
  parameter int                DEPTH    = 5,
  parameter int                STRIDE   = 1,
  parameter logic [DATA_W-1:0] FILL_VAL = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [DEPTH*DATA_W-1:0]    win_data,
  output logic [DEPTH-1:0]           win_mask,
  output logic                       win_full,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);

  typedef enum logic [1:0] {EMPTY, FILLING, STEADY} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        fill_reg, fill_next;
  logic [CNT_W-1:0]        stride_reg, stride_next;
  logic [DEPTH-1:0]        mask_reg, mask_next;
  logic                    win_valid_reg, win_valid_next;
  logic                    win_full_reg;
  logic [DEPTH*DATA_W-1:0] win_reg, win_next;
  logic                    accept, transfer, emit;

  // A pending, unconsumed window blocks input so it can never be overwritten.
  assign in_ready = !rst && !flush && (!win_valid_reg || win_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = win_valid_reg && win_ready;

  // Shifted window contents: each slot takes its newer neighbour, the top
  // slot takes the incoming point.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == DEPTH-1) begin : g_top
        assign win_next[gi*DATA_W +: DATA_W] = in_data;
      end else begin : g_mid
        assign win_next[gi*DATA_W +: DATA_W] = win_reg[(gi+1)*DATA_W +: DATA_W];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    fill_next      = fill_reg;
    stride_next    = stride_reg;
    mask_next      = mask_reg;
    win_valid_next = win_valid_reg;
    emit           = 1'b0;

    if (transfer) begin
      win_valid_next = 1'b0;
    end

    if (flush) begin
      state_next     = EMPTY;
      fill_next      = '0;
      stride_next    = '0;
      mask_next      = '0;
      win_valid_next = 1'b0;
    end else if (accept) begin
      mask_next = {1'b1, mask_reg[DEPTH-1:1]};
      case (state_reg)
        EMPTY: begin
          fill_next  = ONE_C;
          state_next = FILLING;
        end
        FILLING: begin
          fill_next = fill_reg + ONE_C;
          // The accept that completes the window emits the first one.
          if (fill_reg == LAST_C) begin
            state_next  = STEADY;
            stride_next = '0;
            emit        = 1'b1;
          end
        end
        STEADY: begin
          if (stride_reg + ONE_C == STRIDE_C) begin
            stride_next = '0;
            emit        = 1'b1;
          end else begin
            stride_next = stride_reg + ONE_C;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
      // A new trigger wins over a same-cycle transfer: valid stays high.
      if (emit) begin
        win_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      fill_reg      <= '0;
      stride_reg    <= '0;
      mask_reg      <= '0;
      win_valid_reg <= 1'b0;
      win_full_reg  <= 1'b0;
      win_reg       <= {DEPTH{FILL_VAL}};
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      stride_reg    <= stride_next;
      mask_reg      <= mask_next;
      win_valid_reg <= win_valid_next;
      win_full_reg  <= (fill_next == DEPTH_C);
      if (flush) begin
        win_reg <= {DEPTH{FILL_VAL}};
      end else if (accept) begin
        win_reg <= win_next;
      end
    end
  end

  assign win_valid = win_valid_reg;
  assign win_data  = win_reg;
  assign win_mask  = mask_reg;
  assign win_full  = win_full_reg;
  assign fill_cnt  = fill_reg;

endmodule
